// File: rtl/clint_wb_multi.sv
// ---------------------------------------------------------------------------
// clint_wb_multi
//   Multi-hart core-local interruptor behind a Wishbone B4 classic slave.
//   Holds one shared 64-bit mtime counter with a prescaler, plus one
//   mtimecmp and one msip register for each hart.
//
//   Register window (byte offsets from BASE_ADDR, adr[1:0] ignored):
//     0x0000 + 4h   msip[h]        (bit0 only)
//     0x4000 + 8h   mtimecmp[h] lo
//     0x4004 + 8h   mtimecmp[h] hi
//     0xBFF8        mtime lo
//     0xBFFC        mtime hi
//   Anything else inside the window reads 0, ignores writes, and is acked.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wb_cyc_i .. wb_sel_i      Wishbone slave request
//   wb_dat_o, wb_ack_o        read data / single-cycle acknowledge
//   mtip_o [NUM_HARTS]        registered timer interrupt per hart
//   msip_o [NUM_HARTS]        software interrupt per hart
//   time_o [64]               current mtime
// ---------------------------------------------------------------------------
module clint_wb_multi #(
  parameter int unsigned NUM_HARTS = 2,
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  input  logic [3:0]           wb_sel_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic [NUM_HARTS-1:0] mtip_o,
  output logic [NUM_HARTS-1:0] msip_o,
  output logic [63:0]          time_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [63:0]          mtime_q, mtime_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [63:0]          mtimecmp_q [NUM_HARTS];
  logic [63:0]          mtimecmp_d [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q, msip_d;
  logic [NUM_HARTS-1:0] mtip_q, mtip_d;
  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  logic        accept;
  logic        hit;
  logic        acc_hit;
  logic        wr_en;
  logic [13:0] word;
  logic        is_msip;
  logic        is_cmp;
  logic        cmp_hi;
  logic [11:0] msip_idx;
  logic [10:0] cmp_idx;
  logic        is_mtlo;
  logic        is_mthi;
  logic        tick;
  logic [31:0] rdata;
  logic        unused_adr_bits;

  assign unused_adr_bits = &{1'b0, wb_adr_i[1:0]};

  // An ack cycle blocks acceptance, so a held strobe is served every
  // other cycle and never counted twice.
  assign accept   = wb_cyc_i & wb_stb_i & ~ack_q;
  assign hit      = (wb_adr_i[31:16] == BASE_ADDR[31:16]);
  assign acc_hit  = accept & hit;
  assign wr_en    = acc_hit & wb_we_i;

  assign word     = wb_adr_i[15:2];
  assign is_msip  = (word[13:12] == 2'b00);
  assign msip_idx = word[11:0];
  assign is_cmp   = (word[13:12] == 2'b01);
  assign cmp_idx  = word[11:1];
  assign cmp_hi   = word[0];
  assign is_mtlo  = (word == 14'h2FFE);
  assign is_mthi  = (word == 14'h2FFF);

  assign tick     = (presc_q == PRESC_MAX);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_w;
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Read mux (pre-write register state)
  // -------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (is_msip && ({20'd0, msip_idx} == h))
        rdata = {31'd0, msip_q[h[IW-1:0]]};
      if (is_cmp && ({21'd0, cmp_idx} == h))
        rdata = cmp_hi ? mtimecmp_q[h[IW-1:0]][63:32]
                       : mtimecmp_q[h[IW-1:0]][31:0];
    end
    if (is_mtlo) rdata = mtime_q[31:0];
    if (is_mthi) rdata = mtime_q[63:32];
  end

  // -------------------------------------------------------------------------
  // Per-hart registers and timer compare
  // -------------------------------------------------------------------------
  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtip_d     = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (wr_en && is_msip && ({20'd0, msip_idx} == h) && wb_sel_i[0])
        msip_d[h[IW-1:0]] = wb_dat_i[0];
      if (wr_en && is_cmp && ({21'd0, cmp_idx} == h)) begin
        if (cmp_hi)
          mtimecmp_d[h[IW-1:0]][63:32] =
            merge_bytes(mtimecmp_q[h[IW-1:0]][63:32], wb_dat_i, wb_sel_i);
        else
          mtimecmp_d[h[IW-1:0]][31:0] =
            merge_bytes(mtimecmp_q[h[IW-1:0]][31:0], wb_dat_i, wb_sel_i);
      end
      mtip_d[h[IW-1:0]] = (mtime_q >= mtimecmp_q[h[IW-1:0]]);
    end
  end

  // -------------------------------------------------------------------------
  // mtime and prescaler: a bus write to either half wins over a tick and
  // restarts the prescaler.
  // -------------------------------------------------------------------------
  always_comb begin
    mtime_d = mtime_q;
    presc_d = presc_q;
    if (wr_en && (is_mtlo || is_mthi)) begin
      presc_d = '0;
      if (is_mtlo) mtime_d[31:0]  = merge_bytes(mtime_q[31:0],  wb_dat_i, wb_sel_i);
      else         mtime_d[63:32] = merge_bytes(mtime_q[63:32], wb_dat_i, wb_sel_i);
    end else if (tick) begin
      presc_d = '0;
      mtime_d = mtime_q + 64'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Bus response
  // -------------------------------------------------------------------------
  always_comb begin
    ack_d = accept;
    dat_d = acc_hit ? rdata : dat_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mtime_q    <= '0;
      presc_q    <= '0;
      mtimecmp_q <= '{default: '1};
      msip_q     <= '0;
      mtip_q     <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      mtime_q    <= mtime_d;
      presc_q    <= presc_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign mtip_o   = mtip_q;
  assign msip_o   = msip_q;
  assign time_o   = mtime_q;

endmodule

// File: tb/tb_clint_wb_multi.sv
// ---------------------------------------------------------------------------
// tb_clint_wb_multi
//   Directed bench for clint_wb_multi. Two instances share the bus request
//   signals but have separate strobes: dut1 ticks every clock, dut4 every
//   fourth clock. Outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_clint_wb_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb1, stb4, we;
  logic [31:0] adr, dat;
  logic [3:0]  sel;

  logic [31:0] dat1, dat4;
  logic        ack1, ack4;
  logic [1:0]  mtip1, mtip4, msip1, msip4;
  logic [63:0] time1, time4;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  clint_wb_multi #(.NUM_HARTS(2), .BASE_ADDR(32'h2000_0000), .TICK_DIV(1)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb1),
    .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
    .wb_dat_o(dat1), .wb_ack_o(ack1), .mtip_o(mtip1), .msip_o(msip1),
    .time_o(time1)
  );

  clint_wb_multi #(.NUM_HARTS(2), .BASE_ADDR(32'h2000_0000), .TICK_DIV(4)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb4),
    .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
    .wb_dat_o(dat4), .wb_ack_o(ack4), .mtip_o(mtip4), .msip_o(msip4),
    .time_o(time4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One single-beat access; checks ack high in T+1 and low in T+2.
  task automatic xfer(input bit d4, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd);
    @(negedge clk);
    cyc = 1'b1; stb1 = ~d4; stb4 = d4; we = wr; adr = a; dat = d; sel = s;
    @(posedge clk); #1;
    check("ack_high", d4 ? ack4 : ack1, 1'b1);
    rd  = d4 ? dat4 : dat1;
    cyc = 1'b0; stb1 = 1'b0; stb4 = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("ack_low", d4 ? ack4 : ack1, 1'b0);
  endtask

  logic [31:0] rd;
  logic [63:0] exp_t;
  int          acks;
  bit          seen;

  initial begin
    rst = 1'b1; cyc = 1'b0; stb1 = 1'b0; stb4 = 1'b0; we = 1'b0;
    adr = '0; dat = '0; sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", ack1, 1'b0);
    check("rst_mtip", mtip1, 2'b00);
    check("rst_msip", msip1, 2'b00);
    check("rst_time", time1, 64'd0);
    check("rst_dat", dat1, 32'd0);
    rst = 1'b0;

    // mtime counts every clock after reset
    repeat (10) @(posedge clk); #1;
    check("time_10", time1, 64'd10);
    xfer(0, 0, 32'h2000_BFF8, 0, 4'hF, rd);
    check("rd_mtime_lo_10_11", (rd == 32'd10 || rd == 32'd11), 1'b1);
    xfer(0, 0, 32'h2000_4000, 0, 4'hF, rd);
    check("rd_cmp0_lo_rst", rd, 32'hFFFF_FFFF);

    // mtimecmp[1] = 0x40, mtime restarted at 0
    xfer(0, 1, 32'h2000_400C, 32'h0, 4'hF, rd);
    xfer(0, 1, 32'h2000_4008, 32'h40, 4'hF, rd);
    xfer(0, 1, 32'h2000_BFF8, 32'h0, 4'hF, rd);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (time1 == 64'h40) begin seen = 1'b1; break; end
    end
    check("time_reach_40", seen, 1'b1);
    check("mtip1_lag", mtip1[1], 1'b0);
    @(posedge clk); #1;
    check("mtip1_rise", mtip1[1], 1'b1);
    check("mtip0_quiet", mtip1[0], 1'b0);
    xfer(0, 1, 32'h2000_4008, 32'hFFFF_FFFF, 4'hF, rd);
    check("mtip1_fall", mtip1[1], 1'b0);

    // msip
    xfer(0, 1, 32'h2000_0004, 32'hFFFF_FFFF, 4'hF, rd);
    check("msip_set1", msip1, 2'b10);
    xfer(0, 0, 32'h2000_0004, 0, 4'hF, rd);
    check("rd_msip1", rd, 32'h1);
    xfer(0, 1, 32'h2000_0008, 32'hFFFF_FFFF, 4'hF, rd);
    check("msip_absent_nop", msip1, 2'b10);
    xfer(0, 0, 32'h2000_0008, 0, 4'hF, rd);
    check("rd_msip_absent", rd, 32'h0);

    // TICK_DIV=4: wrap with mtimecmp[0]=0
    xfer(1, 1, 32'h2000_4004, 32'h0, 4'hF, rd);
    xfer(1, 1, 32'h2000_4000, 32'h0, 4'hF, rd);
    xfer(1, 1, 32'h2000_BFF8, 32'hFFFF_FFFF, 4'hF, rd);
    xfer(1, 1, 32'h2000_BFFC, 32'hFFFF_FFFF, 4'hF, rd);
    check("wrap_k0", time4, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_mtip_k0", mtip4[0], 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      exp_t = (k < 3) ? 64'hFFFF_FFFF_FFFF_FFFF : (k < 7) ? 64'd0 : 64'd1;
      check($sformatf("wrap_k%0d", k), time4, exp_t);
      check($sformatf("wrap_mtip_k%0d", k), mtip4[0], 1'b1);
    end

    // Partial write on the tick cycle: write wins, prescaler restarts
    repeat (2) @(posedge clk);
    xfer(1, 1, 32'h2000_BFF8, 32'h1234_5678, 4'b0011, rd);
    check("pwr_no_inc", time4, 64'h0000_0000_0000_5678);
    repeat (2) @(posedge clk); #1;
    check("pwr_hold", time4, 64'h0000_0000_0000_5678);
    @(posedge clk); #1;
    check("pwr_tick", time4, 64'h0000_0000_0000_5679);

    // stb held for 6 cycles -> 3 acks, alternating
    @(negedge clk);
    cyc = 1'b1; stb1 = 1'b1; we = 1'b1; adr = 32'h2000_0000; dat = 32'h1; sel = 4'hF;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold_ack%0d", i), ack1, (i % 2 == 0));
      if (ack1) acks++;
    end
    cyc = 1'b0; stb1 = 1'b0; we = 1'b0;
    check("hold_ack_count", acks, 3);
    check("hold_msip", msip1, 2'b11);

    // Reset on the accept cycle: no ack, write discarded
    @(negedge clk);
    rst = 1'b1;
    cyc = 1'b1; stb1 = 1'b1; we = 1'b1; adr = 32'h2000_4000; dat = 32'h55; sel = 4'hF;
    @(posedge clk); #1;
    check("rst_accept_ack", ack1, 1'b0);
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb1 = 1'b0; we = 1'b0;
    check("rst_accept_msip", msip1, 2'b00);
    xfer(0, 0, 32'h2000_4000, 0, 4'hF, rd);
    check("rst_accept_cmp0", rd, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
